// File: rtl/map_pkg.sv
// Shared types and defaults for the PC next-address sequencer.
package map_pkg;
   localparam int              ADDR_W_DEF       = 8;
   localparam int              STACK_DEPTH_DEF  = 8;
   localparam logic [7:0]      RESET_VECTOR_DEF = 8'h00;
   localparam logic [7:0]      TRAP_VECTOR_DEF  = 8'hF0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;
endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses: synchronous push, asynchronous read of the top entry.
// Contents are not reset; only the pointer is, so a reset drops every entry at once.
module return_stack #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int SP_W  = $clog2(DEPTH) + 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            clr_i,
   input  logic [DW-1:0]   push_dat_i,
   output logic [DW-1:0]   top_o,
   output logic [SP_W-1:0] sp_o,
   output logic            full_o,
   output logic            empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0]   mem_q [DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic [AW-1:0]   wr_idx, top_idx;

   assign wr_idx  = sp_q[AW-1:0];
   assign top_idx = AW'(sp_q - SP_W'(1));
   assign top_o   = mem_q[top_idx];
   assign sp_o    = sp_q;
   assign full_o  = (sp_q == SP_W'(DEPTH));
   assign empty_o = (sp_q == '0);

   always_comb begin
      sp_d = sp_q;
      if (clr_i)       sp_d = '0;
      else if (push_i) sp_d = sp_q + SP_W'(1);
      else if (pop_i)  sp_d = sp_q - SP_W'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sp_q <= '0;
      else        sp_q <= sp_d;
   end

   always_ff @(posedge CLK) begin
      if (push_i) mem_q[wr_idx] <= push_dat_i;
   end
endmodule

// File: rtl/pc_sequencer.sv
// Next-address generator feeding the PC register: increment/jump/call/return plus RUN/HALT/FAULT FSM.
// Build option PC_SEQ_TRAP_EN: stack faults vector to TRAP_VECTOR with a one-cycle oFAULT pulse instead of FAULT.
module pc_sequencer
   import map_pkg::*;
#(
   parameter int                ADDR_W       = ADDR_W_DEF,
   parameter int                STACK_DEPTH  = STACK_DEPTH_DEF,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [ADDR_W-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
   parameter int                SP_W         = $clog2(STACK_DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              iEN,
   input  logic              iJMP,
   input  logic              iCALL,
   input  logic              iRET,
   input  logic              iHALT,
   input  logic              iRESUME,
   input  logic [ADDR_W-1:0] iTARGET,
   output logic [ADDR_W-1:0] oNEXT_ADDR,
   output logic [ADDR_W-1:0] oPC,
   output logic [SP_W-1:0]   oSP,
   output logic              oFULL,
   output logic              oEMPTY,
   output logic              oFAULT
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, next_d, pc_inc, stk_top;
   logic              fault_q, fault_d, fault_evt;
   logic              push, pop, clr, stk_full, stk_empty;

   assign pc_inc = pc_q + ADDR_W'(1);

   return_stack #(.DW(ADDR_W), .DEPTH(STACK_DEPTH), .SP_W(SP_W)) u_stack (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .push_i     (push),
      .pop_i      (pop),
      .clr_i      (clr),
      .push_dat_i (pc_inc),
      .top_o      (stk_top),
      .sp_o       (oSP),
      .full_o     (stk_full),
      .empty_o    (stk_empty)
   );

   always_comb begin
      state_d   = state_q;
      next_d    = pc_q;
      push      = 1'b0;
      pop       = 1'b0;
      clr       = 1'b0;
      fault_evt = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (iEN) begin
               if (iHALT) begin
                  state_d = ST_HALT;
               end else if (iRET) begin
                  if (stk_empty) fault_evt = 1'b1;
                  else begin
                     pop    = 1'b1;
                     next_d = stk_top;
                  end
               end else if (iCALL) begin
                  if (stk_full) fault_evt = 1'b1;
                  else begin
                     push   = 1'b1;
                     next_d = iTARGET;
                  end
               end else if (iJMP) begin
                  next_d = iTARGET;
               end else begin
                  next_d = pc_inc;
               end
`ifdef PC_SEQ_TRAP_EN
               if (fault_evt) next_d = TRAP_VECTOR;
`else
               if (fault_evt) state_d = ST_FAULT;
`endif
            end
         end
         ST_HALT: if (iRESUME) state_d = ST_RUN;
         ST_FAULT: begin
            if (iRESUME) begin
               state_d = ST_RUN;
               clr     = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
`ifdef PC_SEQ_TRAP_EN
      fault_d = fault_evt;
`else
      fault_d = (state_d == ST_FAULT);
`endif
   end

`ifndef PC_SEQ_TRAP_EN
   logic unused_trap_vector;
   assign unused_trap_vector = ^TRAP_VECTOR;
`endif

   // Reset must reach the PC register's input combinationally, not a cycle late.
   assign oNEXT_ADDR = RST_N ? next_d : RESET_VECTOR;
   assign oPC        = pc_q;
   assign oFAULT     = fault_q;
   assign oFULL      = stk_full;
   assign oEMPTY     = stk_empty;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_VECTOR;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= next_d;
         fault_q <= fault_d;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expectations per driven cycle.
module tb_pc_sequencer;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       iEN = 0, iJMP = 0, iCALL = 0, iRET = 0, iHALT = 0, iRESUME = 0;
   logic [7:0] iTARGET = '0;
   logic [7:0] oNEXT_ADDR, oPC;
   logic [3:0] oSP;
   logic       oFULL, oEMPTY, oFAULT;

   int n_vec = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   pc_sequencer dut (
      .CLK(CLK), .RST_N(RST_N), .iEN(iEN), .iJMP(iJMP), .iCALL(iCALL), .iRET(iRET),
      .iHALT(iHALT), .iRESUME(iRESUME), .iTARGET(iTARGET), .oNEXT_ADDR(oNEXT_ADDR),
      .oPC(oPC), .oSP(oSP), .oFULL(oFULL), .oEMPTY(oEMPTY), .oFAULT(oFAULT)
   );

   typedef struct {
      logic [7:0] nxt;
      logic [7:0] pc;
      logic [3:0] sp;
      logic       fault;
      logic       full;
      logic       empty;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state: 0 RUN, 1 HALT, 2 FAULT
   int         m_state;
   logic [7:0] m_pc;
   int         m_sp;
   logic [7:0] m_stk [8];
   logic       m_fault;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = 8'h00; m_sp = 0; m_fault = 1'b0;
   endtask

   task automatic step(input logic en, jmp, call, ret, halt, resume, input logic [7:0] tgt);
      exp_t       e, g;
      logic [7:0] nxt;
      int         nstate, nsp;
      logic       evt;
      logic       do_push;
      iEN = en; iJMP = jmp; iCALL = call; iRET = ret; iHALT = halt; iRESUME = resume; iTARGET = tgt;
      nxt = m_pc; nstate = m_state; nsp = m_sp; evt = 1'b0; do_push = 1'b0;
      if (m_state == 0 && en) begin
         if (halt) nstate = 1;
         else if (ret) begin
            if (m_sp == 0) evt = 1'b1;
            else begin nsp = m_sp - 1; nxt = m_stk[m_sp-1]; end
         end else if (call) begin
            if (m_sp == 8) evt = 1'b1;
            else begin do_push = 1'b1; nsp = m_sp + 1; nxt = tgt; end
         end else if (jmp) nxt = tgt;
         else nxt = m_pc + 8'd1;
`ifdef PC_SEQ_TRAP_EN
         if (evt) nxt = 8'hF0;
`else
         if (evt) nstate = 2;
`endif
      end else if (m_state == 1 && resume) nstate = 0;
      else if (m_state == 2 && resume) begin nstate = 0; nsp = 0; end
      e.nxt = nxt; e.pc = m_pc; e.sp = 4'(m_sp); e.fault = m_fault;
      e.full = (m_sp == 8); e.empty = (m_sp == 0);
      exp_q.push_back(e);
      #4;
      g = exp_q.pop_front();
      check("next_addr", oNEXT_ADDR, g.nxt);
      check("pc", oPC, g.pc);
      check("sp", oSP, g.sp);
      check("fault", oFAULT, g.fault);
      check("full", oFULL, g.full);
      check("empty", oEMPTY, g.empty);
      @(posedge CLK);
      if (do_push) m_stk[m_sp] = m_pc + 8'd1;
      m_pc = nxt; m_sp = nsp; m_state = nstate;
`ifdef PC_SEQ_TRAP_EN
      m_fault = evt;
`else
      m_fault = (nstate == 2);
`endif
      #1;
   endtask

   task automatic idle(); step(1, 0, 0, 0, 0, 0, 8'h00); endtask
   task automatic jmp(input logic [7:0] t); step(1, 1, 0, 0, 0, 0, t); endtask
   task automatic call(input logic [7:0] t); step(1, 0, 1, 0, 0, 0, t); endtask
   task automatic ret(); step(1, 0, 0, 1, 0, 0, 8'h00); endtask
   task automatic resume(); step(0, 0, 0, 0, 0, 1, 8'h00); endtask

   initial begin
      model_reset();
      #2;
      check("rst_next", oNEXT_ADDR, 8'h00);
      check("rst_pc", oPC, 8'h00);
      check("rst_sp", oSP, 0);
      check("rst_empty", oEMPTY, 1);
      check("rst_full", oFULL, 0);
      check("rst_fault", oFAULT, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;

      repeat (3) idle();
      step(0, 1, 0, 0, 0, 0, 8'h77);                 // iEN low holds
      jmp(8'h10);
      call(8'h40);
      idle();
      ret();
      idle();
      call(8'h60); ret(); call(8'h70); ret();        // back-to-back call/ret

      for (int i = 0; i < 8; i++) call(8'h50 + 8'(i));
      call(8'hA0);                                   // overflow
      idle(); idle();
      resume();
      while (m_sp > 0) ret();
      ret();                                         // underflow
      idle();
      resume();
      idle();

      jmp(8'h20);
      step(1, 1, 1, 0, 1, 0, 8'h33);                 // halt wins over call and jmp
      idle(); step(1, 1, 1, 1, 0, 0, 8'h44);         // ignored in HALT
      resume();
      idle();

      jmp(8'hFF); idle();
      jmp(8'hFF); call(8'h30); ret(); idle();

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
              8'($urandom));
      if (m_state != 0) resume();

      jmp(8'hFF);
      iEN = 1; iCALL = 1; iJMP = 0; iRET = 0; iHALT = 0; iRESUME = 0; iTARGET = 8'h90;
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      check("midrst_next", oNEXT_ADDR, 8'h00);
      check("midrst_sp", oSP, 0);
      check("midrst_pc", oPC, 8'h00);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address generator directly upstream of the PC register stage.
- Drives that register's 8-bit address input every cycle.
- Selects the next address from increment, jump, call or return. Holds an internal return-address stack and its stack pointer (SP), which the core currently lacks.
- Keeps a shadow copy of the current PC, so the PC register stays a plain one-cycle pipeline register.

Parameters:
- ADDR_W, 8, width of program addresses.
- STACK_DEPTH, 8, return-stack entries; power of two, 2..16.
- RESET_VECTOR, 8'h00, address presented after reset.
- TRAP_VECTOR, 8'hF0, stack-fault handler address (optional feature only).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- iEN  in  1  advance; when low, the sequencer holds the current PC.
- iJMP  in  1  jump to iTARGET.
- iCALL  in  1  push PC+1, jump to iTARGET.
- iRET  in  1  pop the stack into the PC.
- iHALT  in  1  enter HALT.
- iRESUME  in  1  leave HALT or FAULT, back to RUN.
- iTARGET  in  ADDR_W  jump/call destination.
- oNEXT_ADDR  out  ADDR_W  next address; combinational; feeds the PC register's address input.
- oPC  out  ADDR_W  shadow of the current PC, registered.
- oSP  out  log2(STACK_DEPTH)+1  stack occupancy, registered.
- oFULL  out  1  oSP == STACK_DEPTH.
- oEMPTY  out  1  oSP == 0.
- oFAULT  out  1  high while in FAULT, registered.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=RUN, pc_q=RESET_VECTOR, sp=0.
  - oFAULT=0, oFULL=0, oEMPTY=1.
  - Stack contents undefined.
  - oNEXT_ADDR=RESET_VECTOR while RST_N is low.
- States:
  - RUN: normal sequencing.
  - HALT: oNEXT_ADDR=pc_q; all inputs ignored except iRESUME (next state RUN, PC unchanged).
  - FAULT: same as HALT, and oFAULT=1. iRESUME returns to RUN with sp cleared to 0.
- RUN with iEN=0: oNEXT_ADDR=pc_q; nothing changes.
- RUN with iEN=1, priority order (highest first):
  1. iHALT: next state HALT, oNEXT_ADDR=pc_q.
  2. iRET:
     - empty: underflow; go to FAULT, oNEXT_ADDR=pc_q.
     - otherwise: oNEXT_ADDR=stack[sp-1], sp-=1.
  3. iCALL:
     - full: overflow; go to FAULT, oNEXT_ADDR=pc_q.
     - otherwise: stack[sp]=pc_q+1, sp+=1, oNEXT_ADDR=iTARGET.
  4. iJMP: oNEXT_ADDR=iTARGET.
  5. Otherwise: oNEXT_ADDR=pc_q+1.
- Lower-priority requests asserted in the same cycle are dropped silently.
- On every rising edge, pc_q <= oNEXT_ADDR. oPC therefore equals the PC register's output one cycle later.
- Arithmetic:
  - pc_q+1 is modulo 2^ADDR_W; 8'hFF wraps to 8'h00 with no flag.
  - The pushed return address 8'hFF+1 is stored as 8'h00.
- Latency: a request in cycle n sets oNEXT_ADDR in cycle n; oPC shows the new address in n+1.
- A CALL straight after a RET, or the reverse, works back-to-back with no bubble.
- A reset asserted mid-operation aborts any push/pop in progress; no partial stack update is visible after reset.

Optional Feature:
- Macro: PC_SEQ_TRAP_EN.
- Defined:
  - Overflow or underflow does not enter FAULT; oNEXT_ADDR=TRAP_VECTOR and the state stays RUN.
  - oFAULT pulses high for exactly one cycle (registered); sp is unchanged.
  - FAULT state is unreachable; iRESUME affects HALT only.
- Undefined: the FAULT behaviour above; the TRAP_VECTOR parameter is unused.

Decomposition:
- Shared package map_pkg:
  - ADDR_W default.
  - State enum (ST_RUN, ST_HALT, ST_FAULT).
  - RESET_VECTOR/TRAP_VECTOR defaults.
- One sub-module, return_stack: array, sp, full/empty, push/pop strobes, synchronous write, asynchronous read of top entry.
- Next-address mux and FSM stay in pc_sequencer.

Test Plan:
- Reset, then iEN=1 for 3 cycles -> oNEXT_ADDR 00,01,02,03; oPC trails by one cycle; oEMPTY=1.
- At pc 10, iCALL iTARGET=40; at 41, iRET -> oNEXT_ADDR=40, then 11 after the RET; oSP 0->1->0.
- 8 nested CALLs, then a 9th -> oFULL=1 after the 8th. 9th: FAULT, oFAULT=1, oNEXT_ADDR frozen. With PC_SEQ_TRAP_EN: oNEXT_ADDR=F0, one-cycle oFAULT, oSP=8.
- iRET with oSP=0 -> FAULT (or F0 with the macro); iRESUME -> RUN, oSP=0.
- iHALT+iCALL+iJMP together at pc 20 -> HALT, oNEXT_ADDR stays 20, oSP unchanged; iRESUME -> 21 next.
- pc FF, iEN=1 -> oNEXT_ADDR=00. CALL at FF pushes 00. RST_N low mid-CALL -> oNEXT_ADDR=00 immediately, oSP=0.
